decode_stage: RTL and testbench

Single-stage RV32I instruction decoder and operand-hazard scoreboard, sitting directly upstream of `register_file`. It accepts fetched instructions over a valid/ready handshake and extracts register addresses, immediate, control class and write-back intent into one output pipeline register. It drives `rs1`/`rs2`/`rd` toward the register file and stalls issue while a source or destination register has an outstanding write.

---
 rtl/decode_stage.sv | 219 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I single-stage decoder with a write-pending scoreboard that stalls issue on RAW/WAW hazards.
// Define DECODE_SCOREBOARD_EN to build the scoreboard; otherwise hazard is tied low.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] out_imm,
    output logic [3:0]  out_class,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_rd_write,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd
);

    typedef enum logic [3:0] {
        ClsLui     = 4'd0,
        ClsAuipc   = 4'd1,
        ClsJal     = 4'd2,
        ClsJalr    = 4'd3,
        ClsBranch  = 4'd4,
        ClsLoad    = 4'd5,
        ClsStore   = 4'd6,
        ClsOpImm   = 4'd7,
        ClsOp      = 4'd8,
        ClsIllegal = 4'd15
    } cls_e;

    logic [6:0]  opcode;
    logic [4:0]  cand_rs1;
    logic [4:0]  cand_rs2;
    logic [4:0]  cand_rd;
    cls_e        cand_cls;
    logic [31:0] cand_imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        cand_rd_write;
    logic        hazard;
    logic        accept;

    assign opcode   = in_instruction[6:0];
    assign cand_rs1 = in_instruction[19:15];
    assign cand_rs2 = in_instruction[24:20];
    assign cand_rd  = in_instruction[11:7];

    always_comb begin
        cand_cls  = ClsIllegal;
        cand_imm  = 32'd0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        unique case (opcode)
            7'b0110111: begin
                cand_cls  = ClsLui;
                cand_imm  = {in_instruction[31:12], 12'd0};
                writes_rd = 1'b1;
            end
            7'b0010111: begin
                cand_cls  = ClsAuipc;
                cand_imm  = {in_instruction[31:12], 12'd0};
                writes_rd = 1'b1;
            end
            7'b1101111: begin
                cand_cls  = ClsJal;
                cand_imm  = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                             in_instruction[20], in_instruction[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            7'b1100111: begin
                cand_cls  = ClsJalr;
                cand_imm  = {{20{in_instruction[31]}}, in_instruction[31:20]};
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            7'b1100011: begin
                cand_cls = ClsBranch;
                cand_imm = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                            in_instruction[30:25], in_instruction[11:8], 1'b0};
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            7'b0000011: begin
                cand_cls  = ClsLoad;
                cand_imm  = {{20{in_instruction[31]}}, in_instruction[31:20]};
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            7'b0100011: begin
                cand_cls = ClsStore;
                cand_imm = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            7'b0010011: begin
                cand_cls  = ClsOpImm;
                cand_imm  = {{20{in_instruction[31]}}, in_instruction[31:20]};
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            7'b0110011: begin
                cand_cls  = ClsOp;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            default: begin
                cand_cls = ClsIllegal;
            end
        endcase
    end

    assign cand_rd_write = writes_rd & (cand_rd != 5'd0);
    assign in_ready      = (~out_valid | out_ready) & ~hazard;
    assign accept        = in_valid & in_ready;

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [31:0] pending_eff;

    // Write-back clear is applied before the hazard check: the register file write lands this edge.
    always_comb begin
        pending_eff = pending_q;
        if (wb_valid) begin
            pending_eff[wb_rd] = 1'b0;
        end
    end

    always_comb begin
        pending_d = pending_eff;
        if (accept && cand_rd_write) begin
            pending_d[cand_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign hazard = (use_rs1 & pending_eff[cand_rs1]) |
                    (use_rs2 & pending_eff[cand_rs2]) |
                    (cand_rd_write & pending_eff[cand_rd]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, use_rs1, use_rs2};
    assign hazard    = 1'b0;
`endif

    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] out_imm_q;
    cls_e        out_class_q;
    logic [2:0]  out_funct3_q;
    logic        out_funct7b5_q;
    logic        out_rd_write_q;
    logic        out_illegal_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= 32'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            rd_q           <= 5'd0;
            out_imm_q      <= 32'd0;
            out_class_q    <= ClsLui;
            out_funct3_q   <= 3'd0;
            out_funct7b5_q <= 1'b0;
            out_rd_write_q <= 1'b0;
            out_illegal_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q    <= 1'b1;
            out_pc_q       <= in_pc;
            rs1_q          <= cand_rs1;
            rs2_q          <= cand_rs2;
            rd_q           <= cand_rd;
            out_imm_q      <= cand_imm;
            out_class_q    <= cand_cls;
            out_funct3_q   <= in_instruction[14:12];
            out_funct7b5_q <= in_instruction[30];
            out_rd_write_q <= cand_rd_write;
            out_illegal_q  <= (cand_cls == ClsIllegal);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign rd           = rd_q;
    assign out_imm      = out_imm_q;
    assign out_class    = out_class_q;
    assign out_funct3   = out_funct3_q;
    assign out_funct7b5 = out_funct7b5_q;
    assign out_rd_write = out_rd_write_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard, back-pressure and reset sequences.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
    localparam bit Sb = 1'b1;
`else
    localparam bit Sb = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instruction = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] out_imm;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_rd_write;
    logic        out_illegal;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .out_imm        (out_imm),
        .out_class      (out_class),
        .out_funct3     (out_funct3),
        .out_funct7b5   (out_funct7b5),
        .out_rd_write   (out_rd_write),
        .out_illegal    (out_illegal),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
        logic        rdw;
        logic        ill;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an instruction, wait (bounded) for in_ready, take the accepting edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input string name);
        int waits;
        waits          = 0;
        in_instruction = instr;
        in_pc          = pc;
        in_valid       = 1'b1;
        #1;
        while (!in_ready && waits < 20) begin
            step();
            waits++;
        end
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        step();
        wb_valid = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 4'd7,  5'd0,  5'd5,  5'd1,  32'h00000005, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h00108133, 4'd8,  5'd1,  5'd1,  5'd2,  32'h00000000, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h123452B7, 4'd0,  5'd8,  5'd3,  5'd5,  32'h12345000, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'hFE000EE3, 4'd4,  5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 4'd15, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h00512423, 4'd6,  5'd2,  5'd5,  5'd8,  32'h00000008, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFDFF0EF, 4'd2,  5'd31, 5'd29, 5'd1,  32'hFFFFFFFC, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h00008067, 4'd3,  5'd1,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFF22183, 4'd5,  5'd4,  5'd31, 5'd3,  32'hFFFFFFFF, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h80000397, 4'd1,  5'd0,  5'd0,  5'd7,  32'h80000000, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h40335313, 4'd7,  5'd6,  5'd3,  5'd6,  32'h00000403, 3'd5, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{32'h0000000F, 4'd15, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'h00000073, 4'd15, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1};

        // Reset state
        #3;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        #9;
        reset = 1'b1;
        step();

        // Decode table
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].instr, 32'h1000 + 32'(i * 4), $sformatf("vec%0d", i));
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d out_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            check($sformatf("vec%0d class", i), {28'd0, out_class}, {28'd0, vecs[i].cls});
            check($sformatf("vec%0d rs1", i), {27'd0, rs1}, {27'd0, vecs[i].rs1});
            check($sformatf("vec%0d rs2", i), {27'd0, rs2}, {27'd0, vecs[i].rs2});
            check($sformatf("vec%0d rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d imm", i), out_imm, vecs[i].imm);
            check($sformatf("vec%0d funct3", i), {29'd0, out_funct3}, {29'd0, vecs[i].f3});
            check($sformatf("vec%0d funct7b5", i), {31'd0, out_funct7b5}, {31'd0, vecs[i].f7b5});
            check($sformatf("vec%0d rd_write", i), {31'd0, out_rd_write}, {31'd0, vecs[i].rdw});
            check($sformatf("vec%0d illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
            retire(vecs[i].rd);
        end

        // RAW hazard on x1, released by a same-cycle write-back
        issue(32'h00500093, 32'h3000, "addi x1");
        in_instruction = 32'h00108133;
        in_pc          = 32'h3004;
        #1;
        check("raw stall c0", {31'd0, in_ready}, {31'd0, !Sb});
        step();
        check("raw stall c1", {31'd0, in_ready}, {31'd0, !Sb});
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        in_valid = 1'b1;
        #1;
        check("raw wb release", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("raw add class", {28'd0, out_class}, 32'd8);
        check("raw add rd", {27'd0, rd}, 32'd2);
        check("raw add pc", out_pc, 32'h3004);
        retire(5'd2);

        // Illegal with nonzero rd field must not mark rd pending
        issue(32'h0000070B, 32'h3100, "illegal rd14");
        check("illegal rd14 flag", {31'd0, out_illegal}, 32'd1);
        in_instruction = 32'h00100713;
        #1;
        check("illegal no pending", {31'd0, in_ready}, 32'd1);
        issue(32'h00100713, 32'h3104, "addi x14");
        retire(5'd14);

        // Set beats clear when write-back and accept hit the same register
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        issue(32'h00100493, 32'h3200, "addi x9 a");
        wb_valid       = 1'b0;
        in_instruction = 32'h00100493;
        #1;
        check("set wins waw", {31'd0, in_ready}, {31'd0, !Sb});
        retire(5'd9);
        check("x9 cleared", {31'd0, in_ready}, 32'd1);
        step();

        // Back-pressure: hold three cycles, then release
        out_ready = 1'b0;
        issue(32'h00512423, 32'h4000, "bp A");
        in_instruction = 32'h00512423;
        in_pc          = 32'h4004;
        in_valid       = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp hold ready c%0d", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp hold pc c%0d", c), out_pc, 32'h4000);
            check($sformatf("bp hold valid c%0d", c), {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("bp B pc", out_pc, 32'h4004);
        check("bp B valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp drain valid", {31'd0, out_valid}, 32'd0);
        check("bp no dup pc", out_pc, 32'h4004);

        // Back-to-back throughput
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instruction = 32'h00512423;
            in_pc          = 32'h5000 + 32'(k * 4);
            #1;
            check($sformatf("tput ready %0d", k), {31'd0, in_ready}, 32'd1);
            step();
            check($sformatf("tput pc %0d", k), out_pc, 32'h5000 + 32'(k * 4));
        end
        in_valid = 1'b0;
        step();

        // Asynchronous reset mid-stream with pending x3
        issue(32'h00100193, 32'h6000, "addi x3");
        check("pre-reset valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset valid", {31'd0, out_valid}, 32'd0);
        check("async reset pc", out_pc, 32'd0);
        check("async reset imm", out_imm, 32'd0);
        check("async reset rd", {27'd0, rd}, 32'd0);
        check("async reset rd_write", {31'd0, out_rd_write}, 32'd0);
        #2;
        reset = 1'b1;
        in_instruction = 32'h00100193;
        #1;
        check("reset clears pending", {31'd0, in_ready}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
